// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
// The mux integration uses the same requester count and select width.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  // One-hot vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [ADDR_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: searches Req starting one past the
// previous winner, wrapping 3->0, so the previous winner is considered last.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ADDR_W-1:0]  i_last,
  output logic               o_found,
  output logic [ADDR_W-1:0]  o_win
);

  logic [ADDR_W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_found = 1'b0;
    o_win   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = i_last + ADDR_W'(k);
      if (i_req[w_idx]) begin
        o_found = 1'b1;
        o_win   = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 single-bit mux.
// Grants one requester at a time with bounded tenure and a one-cycle
// turnaround between owners; Address moves only when a new tenure starts.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [NUM_REQ-1:0] Req,
  output logic [NUM_REQ-1:0] Grant,
  output logic [ADDR_W-1:0]  Address,
  output logic               Busy,
  output logic               Turn
);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_last;
  logic [NUM_REQ-1:0]  r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_busy;
  logic                r_turn;

  state_t              w_state_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [ADDR_W-1:0]   w_last_next;
  logic [NUM_REQ-1:0]  w_grant_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic                w_busy_next;
  logic                w_turn_next;

  logic                w_found;
  logic [ADDR_W-1:0]   w_win;
  logic                w_others;
  logic                w_expired;

  rr_pick4 u_pick (
    .i_req   (Req),
    .i_last  (r_last),
    .o_found (w_found),
    .o_win   (w_win)
  );

  // Another requester is waiting while the current owner holds the line.
  assign w_others  = |(Req & ~r_grant);
  assign w_expired = (r_cnt == CNT_W'(MAX_HOLD));

  // Next-state and next-output decisions; all outputs come from registers.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_last_next  = r_last;
    w_grant_next = r_grant;
    w_addr_next  = r_addr;
    w_busy_next  = r_busy;
    w_turn_next  = 1'b0;
    case (r_state)
      ST_IDLE, ST_TURN: begin
        // TURN re-arbitrates like IDLE; r_last holds the released owner,
        // which makes it the lowest priority candidate.
        if (w_found) begin
          w_state_next = ST_OWN;
          w_grant_next = onehot4(w_win);
          w_addr_next  = w_win;
          w_last_next  = w_win;
          w_cnt_next   = CNT_W'(1);
          w_busy_next  = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
          w_grant_next = '0;
          w_busy_next  = 1'b0;
        end
      end
      ST_OWN: begin
        if (!Req[r_addr] || (w_expired && w_others)) begin
          w_state_next = ST_TURN;
          w_grant_next = '0;
          w_busy_next  = 1'b0;
          w_turn_next  = 1'b1;
          w_cnt_next   = '0;
        end else if (w_expired) begin
          // Nobody else is waiting: start a fresh tenure silently.
          w_cnt_next = CNT_W'(1);
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
        w_busy_next  = 1'b0;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State and output registers; reset takes effect without a clock edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= ADDR_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_turn  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_last  <= w_last_next;
      r_grant <= w_grant_next;
      r_addr  <= w_addr_next;
      r_busy  <= w_busy_next;
      r_turn  <= w_turn_next;
    end
  end

  assign Grant   = r_grant;
  assign Address = r_addr;
  assign Busy    = r_busy;
  assign Turn    = r_turn;

endmodule
